reg_seq: RTL and testbench
==========================

# reg_seq

Register-file access sequencer for the 16-bit datapath. It accepts one register operation at a time from the control unit and drives the one-hot per-register `en`, `selA` and `selB` lines of the `reg16` instances. Each operation steps through source read, execute wait and writeback. At most one register ever drives each tri-state selector bus, and a stalled datapath is aborted by a timeout.

## Interface

Parameters:
- `NREG`, 8: number of registers sequenced; must satisfy `NREG <= 2**AW`
- `AW`, 3: register address width
- `TMO`, 15: maximum EXEC cycles to wait for `alu_done` (1..255)

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  operation request
- `req_ready`  out  1  sequencer can accept a request
- `ra`  in  AW  source register for selector A
- `rb`  in  AW  source register for selector B
- `rd`  in  AW  destination register
- `wb`  in  1  writeback required
- `alu_done`  in  1  datapath result is valid on the bus
- `en`  out  NREG  one-hot register load enable
- `selA`  out  NREG  one-hot A-selector drive enable
- `selB`  out  NREG  one-hot B-selector drive enable
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle timeout pulse, concurrent with `done`

## Operation

- States: IDLE, READ, EXEC, WRITE, DONE. The FSM is registered and all outputs are decoded from registered state and latched fields.
- **IDLE:**
  - `req_ready` = 1. All of `en`/`selA`/`selB` = 0, so both selector buses float.
  - On `req_valid & req_ready`, latch `ra`, `rb`, `rd` and `wb`, then go to READ.
- **READ:** `selA[ra]` = 1 and `selB[rb]` = 1. Always exactly one cycle, then EXEC. `ra == rb` is legal; the same register drives both buses.
- **EXEC:**
  - `selA`/`selB` are held. The timeout counter clears on READ->EXEC and increments each EXEC cycle.
  - `alu_done` = 1 at an edge: go to WRITE.
  - Otherwise, when the counter reaches `TMO`: go to DONE with the timeout flag set. No write occurs.
  - `alu_done` is ignored in every state except EXEC.
- **WRITE:**
  - `selA`/`selB` are held.
  - `en[rd]` = 1 for exactly this cycle if `wb` = 1; otherwise all `en` = 0.
  - Always one cycle, then DONE.
- **DONE:**
  - All one-hot outputs = 0. `done` = 1, and `err` = timeout flag.
  - Next cycle: IDLE.
- `busy` = 1 in every state except IDLE.
- Out-of-range addresses (index >= `NREG`) assert no bit in the corresponding vector. An out-of-range `rd` suppresses the write. The operation still completes normally.
- Invariant: each of `en`, `selA` and `selB` is zero or one-hot in every cycle.

## Timing

- Reset values: `req_ready`=0 during the reset cycle, then 1. All other outputs = 0. State = IDLE. Timeout counter = 0.
- Request accepted at edge k:
  - READ in cycle k+1.
  - EXEC from k+2.
  - If `alu_done` is sampled high at edge k+2+n (n >= 0): WRITE in cycle k+3+n, DONE in k+4+n, IDLE (ready) in k+5+n.
- Minimum occupancy is 4 cycles (`alu_done` already high on the first EXEC edge).
- Timeout path: `err` and `done` assert `TMO` cycles after EXEC entry. `en` never asserts.
- No back-to-back acceptance: `req_ready` is low from READ through DONE. A `req_valid` held during that time is accepted on return to IDLE.
- `rst` in any state: at the next edge the FSM returns to IDLE, all outputs go to 0, and the in-flight write is cancelled. A reset coinciding with the WRITE cycle still leaves the register updated; that write is the `reg16`'s own concern.
- `ra`/`rb`/`rd`/`wb` are sampled only at acceptance. Changes afterwards have no effect.

## Configuration

- `REG_SEQ_R0_ZERO_EN`:
  - **Defined:** register 0 is read-only.
    - `en[0]` is never asserted; a WRITE with `rd`=0 asserts no `en` bit.
    - Reads of r0 still assert `selA[0]`/`selB[0]`.
    - The team ties r0's bus input to zero at top level.
  - **Undefined:** r0 is a normal writable register.

## Test plan

- Reset, then request `ra`=1, `rb`=2, `rd`=3, `wb`=1, with `alu_done` high on the first EXEC cycle:
  - `selA`=8'h02 and `selB`=8'h04 for 3 cycles.
  - `en`=8'h08 for exactly 1 cycle.
  - `done` pulses at k+4; `req_ready` returns at k+5.
- Same request with `wb`=0 and `alu_done` delayed 5 cycles: `en` stays 8'h00; `done` at k+9; `err`=0.
- `alu_done` never asserted, `TMO`=15: `err`=`done`=1 exactly 15 cycles after EXEC entry; `en` never nonzero.
- `rst` asserted during EXEC: next cycle all outputs are 0, `req_ready`=1, and no `en` pulse follows.
- `rd`=0, `wb`=1:
  - With `REG_SEQ_R0_ZERO_EN` defined: `en` stays 8'h00.
  - Without it: `en`=8'h01 for one cycle.
- `NREG`=6, `ra`=7, `rb`=7: `selA`=`selB`=0 throughout; `done` pulses normally. A one-hot/zero assertion on all three vectors holds in every cycle of every test.

Source files
------------

// File: rtl/reg_seq.sv
// Register-file access sequencer: one operation at a time, READ -> EXEC -> WRITE -> DONE.
// Optional macro REG_SEQ_R0_ZERO_EN makes register 0 read-only (en[0] never asserted).
module reg_seq #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned TMO  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    input  logic [AW-1:0]   rd,
    input  logic            wb,
    input  logic            alu_done,
    output logic [NREG-1:0] en,
    output logic [NREG-1:0] selA,
    output logic [NREG-1:0] selB,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ra_q, rb_q, rd_q;
    logic            wb_q;
    logic            tmo_q, tmo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;

    // Address to one-hot; out-of-range addresses decode to all zeros.
    function automatic logic [NREG-1:0] dec(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    assign accept = (state_q == IDLE) && req_valid && !rst;

    // State, timeout counter and latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            if (accept) begin
                ra_q <= ra;
                rb_q <= rb;
                rd_q <= rd;
                wb_q <= wb;
            end
        end
    end

    // Next state and output decode from registered state and latched fields.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        en        = '0;
        selA      = '0;
        selB      = '0;
        case (state_q)
            IDLE: begin
                req_ready = !rst;
                busy      = 1'b0;
                tmo_d     = 1'b0;
                if (accept) state_d = READ;
            end
            READ: begin
                selA    = dec(ra_q);
                selB    = dec(rb_q);
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                selA  = dec(ra_q);
                selB  = dec(rb_q);
                cnt_d = cnt_q + CW'(1);
                if (alu_done) begin
                    state_d = WRITE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end
            end
            WRITE: begin
                selA = dec(ra_q);
                selB = dec(rb_q);
                if (wb_q) en = dec(rd_q);
`ifdef REG_SEQ_R0_ZERO_EN
                en[0] = 1'b0;
`endif
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                err     = tmo_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_seq.sv
// Directed bench for reg_seq: operation table plus reset and held-request sequences,
// run against an 8-register and a 6-register instance driven by the same inputs.
module tb_reg_seq;

    localparam int TMO = 15;

`ifdef REG_SEQ_R0_ZERO_EN
    localparam logic [7:0] R0_EN = 8'h00;
`else
    localparam logic [7:0] R0_EN = 8'h01;
`endif

    logic       clk = 1'b0;
    logic       rst, req_valid, wb, alu_done;
    logic [2:0] ra, rb, rd;
    logic       req_ready, busy, done, err;
    logic [7:0] en, sel_a, sel_b;
    logic       req_ready6, busy6, done6, err6;
    logic [5:0] en6, sel_a6, sel_b6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_seq #(.NREG(8), .AW(3), .TMO(TMO)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .ra(ra), .rb(rb), .rd(rd), .wb(wb), .alu_done(alu_done),
        .en(en), .selA(sel_a), .selB(sel_b), .busy(busy), .done(done), .err(err)
    );

    reg_seq #(.NREG(6), .AW(3), .TMO(TMO)) u_dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready6),
        .ra(ra), .rb(rb), .rd(rd), .wb(wb), .alu_done(alu_done),
        .en(en6), .selA(sel_a6), .selB(sel_b6), .busy(busy6), .done(done6), .err(err6)
    );

    typedef struct {
        logic [2:0] ra, rb, rd;
        logic       wb;
        int         n;          // alu_done delay in EXEC cycles; -1 = never
        logic [7:0] e_en, e_a, e_b;
        logic [5:0] e_en6, e_a6, e_b6;
    } op_t;

    op_t ops[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle's comparison of both instances plus the zero/one-hot invariant.
    task automatic cyc_chk(input string name,
                           input logic [7:0] e_en, input logic [7:0] e_a, input logic [7:0] e_b,
                           input logic e_busy, input logic e_done, input logic e_err, input logic e_rdy,
                           input logic [5:0] e_en6, input logic [5:0] e_a6, input logic [5:0] e_b6);
        chk({name, " n8"}, {4'h0, en, sel_a, sel_b, busy, done, err, req_ready},
            {4'h0, e_en, e_a, e_b, e_busy, e_done, e_err, e_rdy});
        chk({name, " n6"}, {10'h0, en6, sel_a6, sel_b6, busy6, done6, err6, req_ready6},
            {10'h0, e_en6, e_a6, e_b6, e_busy, e_done, e_err, e_rdy});
        chk({name, " onehot"},
            {31'h0, $onehot0(en) && $onehot0(sel_a) && $onehot0(sel_b) &&
                    $onehot0(en6) && $onehot0(sel_a6) && $onehot0(sel_b6)}, 32'h1);
    endtask

    // Starts on a negedge with the DUT idle; ends on the negedge of the return to IDLE.
    task automatic run_op(input int i);
        op_t  o;
        bit   tmo, act;
        int   c_wr, c_dn, c_id;
        o    = ops[i];
        tmo  = (o.n < 0);
        c_wr = tmo ? -1 : 3 + o.n;
        c_dn = tmo ? TMO + 2 : 4 + o.n;
        c_id = c_dn + 1;
        ra = o.ra; rb = o.rb; rd = o.rd; wb = o.wb;
        req_valid = 1'b1;
        alu_done  = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= c_id; c++) begin
            @(negedge clk);
            act = (c < c_dn);
            cyc_chk($sformatf("op%0d c%0d", i, c),
                    (c == c_wr) ? o.e_en : 8'h00, act ? o.e_a : 8'h00, act ? o.e_b : 8'h00,
                    c < c_id, c == c_dn, tmo && (c == c_dn), c == c_id,
                    (c == c_wr) ? o.e_en6 : 6'h00, act ? o.e_a6 : 6'h00, act ? o.e_b6 : 6'h00);
            if (c == 1) begin
                req_valid = 1'b0;
                ra = ~o.ra; rb = ~o.rb; rd = ~o.rd; wb = ~o.wb;
            end
            // alu_done is also pulsed in READ, where it must be ignored.
            alu_done = (c == 1) || (!tmo && c == 2 + o.n);
        end
        alu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ops[0] = '{3'd1, 3'd2, 3'd3, 1'b1,  0, 8'h08, 8'h02, 8'h04, 6'h08, 6'h02, 6'h04};
        ops[1] = '{3'd1, 3'd2, 3'd3, 1'b0,  5, 8'h00, 8'h02, 8'h04, 6'h00, 6'h02, 6'h04};
        ops[2] = '{3'd4, 3'd4, 3'd5, 1'b1, -1, 8'h00, 8'h10, 8'h10, 6'h00, 6'h10, 6'h10};
        ops[3] = '{3'd0, 3'd0, 3'd0, 1'b1,  1, R0_EN, 8'h01, 8'h01, 6'(R0_EN), 6'h01, 6'h01};
        ops[4] = '{3'd7, 3'd7, 3'd6, 1'b1,  2, 8'h40, 8'h80, 8'h80, 6'h00, 6'h00, 6'h00};
        ops[5] = '{3'd5, 3'd6, 3'd7, 1'b1,  0, 8'h80, 8'h20, 8'h40, 6'h00, 6'h20, 6'h00};

        rst = 1'b1; req_valid = 1'b1; alu_done = 1'b1;
        ra = 3'd1; rb = 3'd2; rd = 3'd3; wb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc_chk("reset_hold", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 6'h00, 6'h00, 6'h00);
        req_valid = 1'b0; alu_done = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cyc_chk("reset_release", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 6'h00, 6'h00, 6'h00);

        for (int i = 0; i < 6; i++) run_op(i);

        // Reset during EXEC cancels the pending write.
        ra = 3'd1; rb = 3'd2; rd = 3'd3; wb = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        cyc_chk("rst_exec pre", 8'h00, 8'h02, 8'h04, 1, 0, 0, 0, 6'h00, 6'h02, 6'h04);
        rst = 1'b1; alu_done = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; alu_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cyc_chk($sformatf("rst_exec post%0d", c), 8'h00, 8'h00, 8'h00, 0, 0, 0, 1,
                    6'h00, 6'h00, 6'h00);
        end

        // req_valid held through an operation is accepted again on return to IDLE.
        ra = 3'd2; rb = 3'd3; rd = 3'd1; wb = 1'b1; req_valid = 1'b1; alu_done = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            int p;
            @(negedge clk);
            p = (c - 1) % 5 + 1;
            cyc_chk($sformatf("held c%0d", c),
                    (p == 3) ? 8'h02 : 8'h00, (p <= 3) ? 8'h04 : 8'h00, (p <= 3) ? 8'h08 : 8'h00,
                    p != 5, p == 4, 0, p == 5,
                    (p == 3) ? 6'h02 : 6'h00, (p <= 3) ? 6'h04 : 6'h00, (p <= 3) ? 6'h08 : 6'h00);
            if (c == 6) req_valid = 1'b0;
        end
        alu_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
